// File: rtl/game_pkg.sv
// Shared encodings for the player movement block: game states, directions, key bits.
package game_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_OVER  = 2'd3
   } game_state_t;

   typedef enum logic [1:0] {
      DIR_UP    = 2'd0,
      DIR_DOWN  = 2'd1,
      DIR_LEFT  = 2'd2,
      DIR_RIGHT = 2'd3
   } dir_t;

   localparam int KEY_UP    = 4;
   localparam int KEY_DOWN  = 3;
   localparam int KEY_LEFT  = 2;
   localparam int KEY_RIGHT = 1;
   localparam int KEY_START = 0;

   function automatic logic is_onehot5(input logic [4:0] v);
      return (v != 5'd0) && ((v & (v - 5'd1)) == 5'd0);
   endfunction

   // Opposite directions differ only in bit 0 with the encoding above.
   function automatic logic is_reversal(input dir_t a, input dir_t b);
      return (a ^ b) == 2'b01;
   endfunction

endpackage

// File: rtl/tick_gen.sv
// Move-rate divider: counts 0..TICK_DIV-1 while run is high, holds otherwise,
// clear forces zero. tick marks the last count of a period while running.
module tick_gen #(
   parameter int TICK_DIV = 5_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic run,
   input  logic clear,
   output logic tick
);

   localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] tick_cnt;

   assign tick = run && (tick_cnt == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tick_cnt <= '0;
      end else if (clear) begin
         tick_cnt <= '0;
      end else if (run) begin
         tick_cnt <= (tick_cnt == LAST) ? '0 : tick_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/player_move_ctrl.sv
// Game-state FSM, direction register and grid position stepping for the player cell.
// Define PLAYER_WRAP_EN to wrap at grid edges instead of ending the game.
module player_move_ctrl
   import game_pkg::*;
#(
   parameter int  GRID_W   = 32,
   parameter int  GRID_H   = 24,
   parameter int  TICK_DIV = 5_000_000,
   localparam int XW       = $clog2(GRID_W),
   localparam int YW       = $clog2(GRID_H)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [4:0]    key_cmd,
   output logic [XW-1:0] pos_x,
   output logic [YW-1:0] pos_y,
   output logic [1:0]    dir,
   output logic [1:0]    game_state,
   output logic          move_pulse,
   output logic          game_over
);

`ifdef PLAYER_WRAP_EN
   localparam bit WRAP_EN = 1'b1;
`else
   localparam bit WRAP_EN = 1'b0;
`endif

   localparam logic [XW-1:0] X_MAX = XW'(GRID_W - 1);
   localparam logic [YW-1:0] Y_MAX = YW'(GRID_H - 1);
   localparam logic [XW-1:0] X_CTR = XW'(GRID_W / 2);
   localparam logic [YW-1:0] Y_CTR = YW'(GRID_H / 2);

   game_state_t   state_q;
   dir_t          dir_q;
   dir_t          dir_req;
   logic [4:0]    cmd_q;
   logic          new_cmd, start_cmd, dir_cmd;
   logic          tick, at_wall;
   logic [XW-1:0] nx;
   logic [YW-1:0] ny;

   assign dir        = dir_q;
   assign game_state = state_q;

   // A held key differs from cmd_q only on its first cycle.
   assign new_cmd   = (key_cmd != cmd_q) && is_onehot5(key_cmd);
   assign start_cmd = new_cmd && key_cmd[KEY_START];
   assign dir_cmd   = new_cmd && !key_cmd[KEY_START];

   always_comb begin
      dir_req = DIR_RIGHT;
      if (key_cmd[KEY_UP])        dir_req = DIR_UP;
      else if (key_cmd[KEY_DOWN]) dir_req = DIR_DOWN;
      else if (key_cmd[KEY_LEFT]) dir_req = DIR_LEFT;
   end

   // Next cell in the current direction; at_wall flags a step off the grid,
   // in which case nx/ny hold the wrapped-around cell.
   always_comb begin
      nx      = pos_x;
      ny      = pos_y;
      at_wall = 1'b0;
      case (dir_q)
         DIR_UP: begin
            if (pos_y == '0) begin at_wall = 1'b1; ny = Y_MAX; end
            else ny = pos_y - 1'b1;
         end
         DIR_DOWN: begin
            if (pos_y == Y_MAX) begin at_wall = 1'b1; ny = '0; end
            else ny = pos_y + 1'b1;
         end
         DIR_LEFT: begin
            if (pos_x == '0) begin at_wall = 1'b1; nx = X_MAX; end
            else nx = pos_x - 1'b1;
         end
         default: begin
            if (pos_x == X_MAX) begin at_wall = 1'b1; nx = '0; end
            else nx = pos_x + 1'b1;
         end
      endcase
   end

   tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
      .clk   (clk),
      .rst_n (rst_n),
      .run   (state_q == ST_RUN),
      .clear ((state_q == ST_IDLE) || (state_q == ST_OVER)),
      .tick  (tick)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         dir_q      <= DIR_RIGHT;
         pos_x      <= X_CTR;
         pos_y      <= Y_CTR;
         cmd_q      <= '0;
         move_pulse <= 1'b0;
         game_over  <= 1'b0;
      end else begin
         cmd_q      <= key_cmd;
         move_pulse <= 1'b0;
         if (start_cmd) begin
            case (state_q)
               ST_IDLE:  state_q <= ST_RUN;
               ST_RUN:   state_q <= ST_PAUSE;
               ST_PAUSE: state_q <= ST_RUN;
               default: begin
                  state_q   <= ST_RUN;
                  pos_x     <= X_CTR;
                  pos_y     <= Y_CTR;
                  dir_q     <= DIR_RIGHT;
                  game_over <= 1'b0;
               end
            endcase
         end else if (state_q == ST_RUN) begin
            if (dir_cmd && !is_reversal(dir_q, dir_req))
               dir_q <= dir_req;
            if (tick) begin
               if (at_wall && !WRAP_EN) begin
                  state_q   <= ST_OVER;
                  game_over <= 1'b1;
               end else begin
                  pos_x      <= nx;
                  pos_y      <= ny;
                  move_pulse <= 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_player_move_ctrl.sv
// Directed table-driven bench for player_move_ctrl (GRID 8x6, TICK_DIV 4).
module tb_player_move_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [4:0] key_cmd;
   logic [2:0] pos_x, pos_y;
   logic [1:0] dir, game_state;
   logic       move_pulse, game_over;

   int checks = 0;
   int errors = 0;

   player_move_ctrl #(.GRID_W(8), .GRID_H(6), .TICK_DIV(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .key_cmd    (key_cmd),
      .pos_x      (pos_x),
      .pos_y      (pos_y),
      .dir        (dir),
      .game_state (game_state),
      .move_pulse (move_pulse),
      .game_over  (game_over)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [4:0] key;
      int         n;
      int         x, y, d, st, go, np;
   } vec_t;

   vec_t tbl[18];

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
      end
   endtask

   // Advance n clock edges, sampling 1 time unit after each; counts move pulses seen.
   task automatic step(input int n, output int pulses);
      pulses = 0;
      repeat (n) begin
         @(posedge clk);
         #1;
         if (move_pulse) pulses++;
      end
   endtask

   task automatic chk_all(input string nm, input int x, input int y, input int d,
                          input int st, input int go);
      chk({nm, ".x"},  int'(pos_x), x);
      chk({nm, ".y"},  int'(pos_y), y);
      chk({nm, ".dir"}, int'(dir), d);
      chk({nm, ".st"}, int'(game_state), st);
      chk({nm, ".go"}, int'(game_over), go);
   endtask

   initial begin
      int np;

      tbl[0]  = '{5'd0,  20, 4, 3, 3, 0, 0, 0};
      tbl[1]  = '{5'd3,   2, 4, 3, 3, 0, 0, 0};
      tbl[2]  = '{5'd1,   1, 4, 3, 3, 1, 0, 0};
      tbl[3]  = '{5'd1,   9, 6, 3, 3, 1, 0, 2};
      tbl[4]  = '{5'd4,   1, 6, 3, 3, 1, 0, 0};
      tbl[5]  = '{5'd16,  1, 6, 3, 0, 1, 0, 0};
      tbl[6]  = '{5'd16,  1, 6, 2, 0, 1, 0, 1};
      tbl[7]  = '{5'd1,   1, 6, 2, 0, 2, 0, 0};
      tbl[8]  = '{5'd1,   5, 6, 2, 0, 2, 0, 0};
      tbl[9]  = '{5'd0,   1, 6, 2, 0, 2, 0, 0};
      tbl[10] = '{5'd1,   1, 6, 2, 0, 1, 0, 0};
      tbl[11] = '{5'd1,   2, 6, 2, 0, 1, 0, 0};
      tbl[12] = '{5'd1,   1, 6, 1, 0, 1, 0, 1};
      tbl[13] = '{5'd2,   1, 6, 1, 3, 1, 0, 0};
      tbl[14] = '{5'd2,   3, 7, 1, 3, 1, 0, 1};
`ifdef PLAYER_WRAP_EN
      tbl[15] = '{5'd2,   4, 0, 1, 3, 1, 0, 1};
      tbl[16] = '{5'd2,   4, 1, 1, 3, 1, 0, 1};
      tbl[17] = '{5'd16,  1, 1, 1, 0, 1, 0, 0};
`else
      tbl[15] = '{5'd2,   4, 7, 1, 3, 3, 1, 0};
      tbl[16] = '{5'd2,   4, 7, 1, 3, 3, 1, 0};
      tbl[17] = '{5'd16,  1, 7, 1, 3, 3, 1, 0};
`endif

      rst_n   = 1'b0;
      key_cmd = 5'd0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;

      for (int i = 0; i < 18; i++) begin
         key_cmd = tbl[i].key;
         step(tbl[i].n, np);
         chk_all($sformatf("v%0d", i), tbl[i].x, tbl[i].y, tbl[i].d, tbl[i].st, tbl[i].go);
         chk($sformatf("v%0d.pulses", i), np, tbl[i].np);
      end

`ifndef PLAYER_WRAP_EN
      // Restart from OVER recentres the player and the first move takes a full period.
      key_cmd = 5'd1;
      step(1, np);
      chk_all("restart", 4, 3, 3, 1, 0);
      step(4, np);
      chk("restart.x_after_tick", int'(pos_x), 5);
      chk("restart.pulses", np, 1);
`endif

      // Asynchronous reset while running takes effect without a clock edge.
      rst_n = 1'b0;
      #2;
      chk_all("async_rst", 4, 3, 3, 0, 0);
      chk("async_rst.pulse", int'(move_pulse), 0);
      key_cmd = 5'd0;
      step(1, np);
      rst_n = 1'b1;

      // Start pressed on the tick cycle: pause wins, no move.
      key_cmd = 5'd1;
      step(1, np);
      chk("st_tick.run", int'(game_state), 1);
      key_cmd = 5'd0;
      step(3, np);
      chk("st_tick.pre_pulses", np, 0);
      key_cmd = 5'd1;
      step(1, np);
      chk_all("st_tick", 4, 3, 3, 2, 0);
      chk("st_tick.pulse", np, 0);
      step(6, np);
      chk("st_tick.frozen_x", int'(pos_x), 4);
      chk("st_tick.frozen_pulses", np, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
